// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
//
// Purpose: decides each cycle whether every pipeline register (F/D, D/X, X/M, M/W)
// holds, advances or loads a NOP. It handles load-use hazards, branch squashes,
// instruction/data memory stalls and the drain sequence after HALT.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   rsAD_i, rsBD_i, useAD_i,
//   useBD_i, haltD_i            source operands / HALT flag of the instruction in D
//   wrtRegX_i, regWrtX_i,
//   readEnX_i, brchTakenX_i     destination / load / taken-branch info of the instruction in X
//   imemStall_i, dmemStall_i    memory not-ready levels
//   pcEn_o, *En_o               PC load enable and pipeline-register advance enables
//   *Flush_o                    load NOP into the register (wins over hold)
//   haltDone_o                  pipe drained after HALT, sticky until reset
//   memTimeout_o                sticky: dmemStall lasted MEM_TIMEOUT consecutive cycles
//   stallCycles_o               saturating count of RUN cycles with pcEn low (not redirects)

module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rsAD_i,
    input  logic [2:0]  rsBD_i,
    input  logic        useAD_i,
    input  logic        useBD_i,
    input  logic        haltD_i,
    input  logic [2:0]  wrtRegX_i,
    input  logic        regWrtX_i,
    input  logic        readEnX_i,
    input  logic        brchTakenX_i,
    input  logic        imemStall_i,
    input  logic        dmemStall_i,
    output logic        pcEn_o,
    output logic        fdEn_o,
    output logic        dxEn_o,
    output logic        xmEn_o,
    output logic        mwEn_o,
    output logic        fdFlush_o,
    output logic        dxFlush_o,
    output logic        xmFlush_o,
    output logic        mwFlush_o,
    output logic        haltDone_o,
    output logic        memTimeout_o,
    output logic [15:0] stallCycles_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_CYCLES - 1);
    localparam logic [16:0] TMO_LIMIT  = 17'(MEM_TIMEOUT);

    state_t      state_q;
    logic [15:0] drain_cnt_q;
    logic [15:0] dstall_cnt_q;
    logic        timeout_q;
    logic [15:0] stall_cnt_q;

    logic        load_use;
    logic        go_drain;
    logic        timeout_hit;
    logic        pc_en, fd_en, dx_en, xm_en, mw_en;
    logic        fd_fl, dx_fl, xm_fl, mw_fl;

    assign load_use = readEnX_i & regWrtX_i &
                      ((useAD_i & (rsAD_i == wrtRegX_i)) |
                       (useBD_i & (rsBD_i == wrtRegX_i)));

    // The current stalled cycle counts toward the limit, so the flag shows up
    // during the MEM_TIMEOUT-th consecutive stall cycle itself.
    assign timeout_hit = dmemStall_i & (({1'b0, dstall_cnt_q} + 17'd1) >= TMO_LIMIT);

    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        dx_en    = 1'b1;
        xm_en    = 1'b1;
        mw_en    = 1'b1;
        fd_fl    = 1'b0;
        dx_fl    = 1'b0;
        xm_fl    = 1'b0;
        mw_fl    = 1'b0;
        go_drain = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (dmemStall_i) begin
                    // Freeze everything up to M; X keeps any taken branch so it is re-presented.
                    pc_en = 1'b0;
                    fd_en = 1'b0;
                    dx_en = 1'b0;
                    xm_en = 1'b0;
                    mw_fl = 1'b1;
                end else if (brchTakenX_i) begin
                    fd_fl = 1'b1;
                    dx_fl = 1'b1;
                end else if (load_use) begin
                    pc_en = 1'b0;
                    fd_en = 1'b0;
                    dx_fl = 1'b1;
                end else if (imemStall_i) begin
                    pc_en = 1'b0;
                    fd_fl = 1'b1;
                end else if (haltD_i) begin
                    pc_en    = 1'b0;
                    fd_fl    = 1'b1;
                    go_drain = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_en = 1'b0;
                fd_fl = 1'b1;
                if (dmemStall_i) begin
                    // D/X may still hold the HALT, so it is held rather than flushed.
                    fd_en = 1'b0;
                    dx_en = 1'b0;
                    xm_en = 1'b0;
                    mw_fl = 1'b1;
                end else begin
                    dx_fl = 1'b1;
                end
            end
            default: begin
                pc_en = 1'b0;
                fd_en = 1'b0;
                dx_en = 1'b0;
                xm_en = 1'b0;
                mw_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            drain_cnt_q  <= 16'd0;
            dstall_cnt_q <= 16'd0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= 16'd0;
        end else begin
            if (dmemStall_i) begin
                if (dstall_cnt_q != 16'hFFFF) begin
                    dstall_cnt_q <= dstall_cnt_q + 16'd1;
                end
            end else begin
                dstall_cnt_q <= 16'd0;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
            if ((state_q == ST_RUN) && !pc_en && !brchTakenX_i && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            case (state_q)
                ST_RUN: begin
                    if (go_drain) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (!dmemStall_i) begin
                        if (drain_cnt_q == 16'd0) begin
                            state_q <= ST_HALTED;
                        end else begin
                            drain_cnt_q <= drain_cnt_q - 16'd1;
                        end
                    end
                end
                default: state_q <= ST_HALTED;
            endcase
        end
    end

    // Reset forces every register to load a NOP without waiting for a clock.
    assign pcEn_o        = pc_en & ~rst;
    assign fdEn_o        = fd_en & ~rst;
    assign dxEn_o        = dx_en & ~rst;
    assign xmEn_o        = xm_en & ~rst;
    assign mwEn_o        = mw_en & ~rst;
    assign fdFlush_o     = fd_fl | rst;
    assign dxFlush_o     = dx_fl | rst;
    assign xmFlush_o     = xm_fl | rst;
    assign mwFlush_o     = mw_fl | rst;
    assign haltDone_o    = (state_q == ST_HALTED) & ~rst;
    assign memTimeout_o  = (timeout_q | timeout_hit) & ~rst;
    assign stallCycles_o = rst ? 16'd0 : stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

    localparam int MT = 4;
    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rsAD, rsBD, wrtRegX;
    logic        useAD, useBD, haltD, regWrtX, readEnX, brchTakenX, imemStall, dmemStall;
    logic        pcEn, fdEn, dxEn, xmEn, mwEn, fdFlush, dxFlush, xmFlush, mwFlush;
    logic        haltDone, memTimeout;
    logic [15:0] stallCycles;

    int checks = 0;
    int passes = 0;

    // Reference model: pipeline mode, remaining drain cycles, consecutive dmem stall run,
    // sticky timeout and stall counter.
    int mode = 0;            // 0 running, 1 draining, 2 halted
    int drain_left = 0;
    int drun = 0;
    bit tmo = 1'b0;
    int stalls = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .rsAD_i(rsAD), .rsBD_i(rsBD), .useAD_i(useAD), .useBD_i(useBD), .haltD_i(haltD),
        .wrtRegX_i(wrtRegX), .regWrtX_i(regWrtX), .readEnX_i(readEnX), .brchTakenX_i(brchTakenX),
        .imemStall_i(imemStall), .dmemStall_i(dmemStall),
        .pcEn_o(pcEn), .fdEn_o(fdEn), .dxEn_o(dxEn), .xmEn_o(xmEn), .mwEn_o(mwEn),
        .fdFlush_o(fdFlush), .dxFlush_o(dxFlush), .xmFlush_o(xmFlush), .mwFlush_o(mwFlush),
        .haltDone_o(haltDone), .memTimeout_o(memTimeout), .stallCycles_o(stallCycles)
    );

    // Expected {pcEn,fdEn,dxEn,xmEn,mwEn, fdFl,dxFl,xmFl,mwFl, haltDone, memTimeout}
    function automatic logic [10:0] expect_outs();
        bit haz, tm;
        logic [8:0] ctl;
        if (rst) return 11'b00000_1111_0_0;
        haz = readEnX && regWrtX && ((useAD && rsAD == wrtRegX) || (useBD && rsBD == wrtRegX));
        tm  = tmo || (dmemStall && (drun + 1 >= MT));
        if (mode == 2) return {9'b00000_0000, 1'b1, tm};
        if (mode == 1) ctl = dmemStall ? 9'b00001_1001 : 9'b01111_1100;
        else if (dmemStall)   ctl = 9'b00001_0001;
        else if (brchTakenX)  ctl = 9'b11111_1100;
        else if (haz)         ctl = 9'b00111_0100;
        else if (imemStall)   ctl = 9'b01111_1000;
        else if (haltD)       ctl = 9'b01111_1000;
        else                  ctl = 9'b11111_0000;
        return {ctl, 1'b0, tm};
    endfunction

    function automatic bit is_halt_entry();
        bit haz;
        haz = readEnX && regWrtX && ((useAD && rsAD == wrtRegX) || (useBD && rsBD == wrtRegX));
        return (mode == 0) && !dmemStall && !brchTakenX && !haz && !imemStall && haltD;
    endfunction

    task automatic model_reset();
        mode = 0; drain_left = 0; drun = 0; tmo = 1'b0; stalls = 0;
    endtask

    task automatic check_now(input string tag);
        logic [10:0] exp_v, obs_v;
        logic [15:0] exp_s;
        exp_v = expect_outs();
        exp_s = rst ? 16'd0 : 16'(stalls);
        obs_v = {pcEn, fdEn, dxEn, xmEn, mwEn, fdFlush, dxFlush, xmFlush, mwFlush, haltDone, memTimeout};
        checks++;
        assert (obs_v === exp_v) passes++;
        else $error("FAIL %s ctl: observed %b expected %b", tag, obs_v, exp_v);
        checks++;
        assert (stallCycles === exp_s) passes++;
        else $error("FAIL %s stallCycles: observed %0d expected %0d", tag, stallCycles, exp_s);
    endtask

    // One clock: check mid-cycle, then advance the model with this cycle's inputs.
    task automatic step(input string tag);
        logic [10:0] e;
        bit enter;
        @(negedge clk);
        check_now(tag);
        e = expect_outs();
        enter = is_halt_entry();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (dmemStall && drun + 1 >= MT) tmo = 1'b1;
            drun = dmemStall ? ((drun < 65535) ? drun + 1 : drun) : 0;
            if (mode == 0 && !e[10] && !brchTakenX && stalls < 65535) stalls++;
            if (enter) begin
                mode = 1; drain_left = DC - 1;
            end else if (mode == 1 && !dmemStall) begin
                if (drain_left == 0) mode = 2;
                else drain_left--;
            end
        end
        #1;
    endtask

    task automatic idle();
        rsAD = 3'd0; rsBD = 3'd0; useAD = 0; useBD = 0; haltD = 0;
        wrtRegX = 3'd0; regWrtX = 0; readEnX = 0; brchTakenX = 0; imemStall = 0; dmemStall = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_now("async_reset");
        step("reset_hold");
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #2;
        do_reset();
        step("idle_run");

        // load-use: LD r3 in X, D reads r3 -> single bubble
        readEnX = 1; regWrtX = 1; wrtRegX = 3'd3; useAD = 1; rsAD = 3'd3;
        step("load_use");
        idle();
        step("after_load_use");
        checks++;
        assert (stallCycles === 16'd1) passes++;
        else $error("FAIL load_use_stall_count: observed %0d expected 1", stallCycles);

        // branch beats load-use and halt
        brchTakenX = 1; readEnX = 1; regWrtX = 1; wrtRegX = 3'd5; useBD = 1; rsBD = 3'd5; haltD = 1;
        step("branch_prio");
        idle();
        step("after_branch");

        // dmemStall for 4 cycles with a pending branch, then the redirect
        brchTakenX = 1; dmemStall = 1;
        for (int i = 0; i < 4; i++) step($sformatf("dmem_branch%0d", i));
        dmemStall = 0;
        step("branch_after_dmem");
        brchTakenX = 0;
        step("timeout_sticky");
        checks++;
        assert (memTimeout === 1'b1) passes++;
        else $error("FAIL timeout_sticky_direct: observed %b expected 1", memTimeout);

        // halt with a 2-cycle dmem stall in the middle of the drain
        do_reset();
        imemStall = 1;
        step("imem_stall");
        imemStall = 0; haltD = 1;
        step("halt_enter");
        haltD = 0;
        step("drain0");
        dmemStall = 1;
        step("drain_dmem0");
        step("drain_dmem1");
        dmemStall = 0;
        for (int i = 0; i < 4; i++) step($sformatf("drain_tail%0d", i));
        checks++;
        assert (haltDone === 1'b1) passes++;
        else $error("FAIL halt_done: observed %b expected 1", haltDone);

        // reset in the middle of the drain
        do_reset();
        haltD = 1;
        step("halt_enter2");
        haltD = 0;
        step("drain_before_reset");
        rst = 1'b1;
        #1;
        model_reset();
        check_now("reset_mid_drain");
        step("reset_mid_drain_clk");
        rst = 1'b0;
        step("run_after_reset");

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rsAD       = 3'($urandom_range(0, 7));
            rsBD       = 3'($urandom_range(0, 7));
            wrtRegX    = 3'($urandom_range(0, 7));
            useAD      = ($urandom_range(0, 1) == 1);
            useBD      = ($urandom_range(0, 1) == 1);
            regWrtX    = ($urandom_range(0, 3) != 0);
            readEnX    = ($urandom_range(0, 2) == 0);
            brchTakenX = (mode == 0) && ($urandom_range(0, 5) == 0);
            imemStall  = ($urandom_range(0, 4) == 0);
            dmemStall  = ($urandom_range(0, 3) == 0);
            haltD      = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_now("rand_async_reset");
                step("rand_reset");
                rst = 1'b0;
            end else begin
                step("rand");
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
